// File: rtl/trivium_pkg.sv
// Shared Trivium constants, FSM encoding and the pure state-load / round functions.
package trivium_pkg;

  localparam int STATE_W       = 288;
  localparam int KEY_W         = 80;
  localparam int IV_W          = 80;
  localparam int WARMUP_ROUNDS = 1152;
  localparam int CNT_W         = 11;

  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(WARMUP_ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } fsm_e;

  typedef struct packed {
    logic [STATE_W-1:0] state;
    logic               z;
  } round_t;

  // Vector bit k holds Trivium cell s[k+1].
  function automatic logic [STATE_W-1:0] trivium_load(
    input logic [KEY_W-1:0] key,
    input logic [IV_W-1:0]  iv
  );
    return {3'b111, 112'b0, iv, 13'b0, key};
  endfunction

  function automatic round_t trivium_round(input logic [STATE_W-1:0] s);
    round_t r;
    logic   t1;
    logic   t2;
    logic   t3;
    t1  = s[65]  ^ s[92];
    t2  = s[161] ^ s[176];
    t3  = s[242] ^ s[287];
    r.z = t1 ^ t2 ^ t3;
    t1  = t1 ^ (s[90]  & s[91])  ^ s[170];
    t2  = t2 ^ (s[174] & s[175]) ^ s[263];
    t3  = t3 ^ (s[285] & s[286]) ^ s[68];
    // Three shift registers s1..s93, s94..s177, s178..s288, each fed at its head.
    r.state = {s[286:177], t2, s[175:93], t1, s[91:0], t3};
    return r;
  endfunction

endpackage

// File: rtl/trivium_core.sv
// Trivium 288-bit state register with load/advance controls; z is the output bit of the current state.
module trivium_core
  import trivium_pkg::*;
(
  input  logic             clk,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [KEY_W-1:0] key_i,
  input  logic [IV_W-1:0]  iv_i,
  output logic             z_o
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  round_t             rnd;

  always_comb begin
    rnd     = trivium_round(state_q);
    state_d = state_q;
    if (load_i) begin
      state_d = trivium_load(key_i, iv_i);
    end else if (step_i) begin
      state_d = rnd.state;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign z_o = rnd.z;

endmodule

// File: rtl/tt_um_trivium.sv
// TinyTapeout wrapper around trivium_core: start/rekey FSM, warm-up counter and port mapping.
// Define TRIVIUM_STATUS_EN to drive valid/busy onto uo_out[2:1].
module tt_um_trivium
  import trivium_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [7:0]       ui_in,
  input  logic [7:0]       uio_in,
  input  logic [KEY_W-1:0] key,
  input  logic [IV_W-1:0]  iv,
  output logic [7:0]       uo_out,
  output logic [7:0]       uio_out,
  output logic [7:0]       uio_oe,
  output logic             keystream_bit
);

  fsm_e             state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             valid_q;
  logic             busy_q;
  logic             start;
  logic             load;
  logic             step;
  logic             z;
  logic [1:0]       status;
  logic             unused_inputs;

  // The reset port is active-high despite its name.
  assign start = ui_in[0];
  assign load  = ena & start;
  assign step  = ena & ~start & (state_q != IDLE);

  trivium_core u_core (
    .clk    (clk),
    .rst_i  (rst_n),
    .load_i (load),
    .step_i (step),
    .key_i  (key),
    .iv_i   (iv),
    .z_o    (z)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (ena) begin
      if (start) begin
        state_q <= INIT;
        cnt_q   <= '0;
        valid_q <= 1'b0;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          INIT: begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_ROUND) begin
              state_q <= RUN;
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign keystream_bit = (state_q == RUN) & z;

`ifdef TRIVIUM_STATUS_EN
  assign status        = {busy_q, valid_q};
  assign unused_inputs = ^{uio_in, ui_in[7:1]};
`else
  assign status        = 2'b00;
  assign unused_inputs = ^{uio_in, ui_in[7:1], valid_q, busy_q};
`endif

  assign uo_out  = {5'b00000, status, keystream_bit};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_trivium.sv
// Self-checking bench for tt_um_trivium: table-driven warm-up sequence plus directed keystream,
// freeze, rekey and mid-warm-up reset sequences against an independent three-register Trivium model.
module tb_tt_um_trivium;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [7:0]  ui_in;
  logic [7:0]  uio_in;
  logic [79:0] key;
  logic [79:0] iv;
  wire  [7:0]  uo_out;
  wire  [7:0]  uio_out;
  wire  [7:0]  uio_oe;
  wire         keystream_bit;

  always #5 clk = ~clk;

  tt_um_trivium dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .ui_in         (ui_in),
    .uio_in        (uio_in),
    .key           (key),
    .iv            (iv),
    .uo_out        (uo_out),
    .uio_out       (uio_out),
    .uio_oe        (uio_oe),
    .keystream_bit (keystream_bit)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference cipher as the classic A(93)/B(84)/C(111) registers, 1-based.
  logic ma [1:93];
  logic mb [1:84];
  logic mc [1:111];
  int   ph;      // 0 idle, 1 warm-up, 2 running
  int   rounds;

  typedef struct {
    logic  e;
    logic  s;
    int    n;
    logic  v;
    logic  b;
    string name;
  } vec_t;
  vec_t tbl [7];

  task automatic check1(input string name, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b want %b (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic model_z();
    return ma[66] ^ ma[93] ^ mb[69] ^ mb[84] ^ mc[66] ^ mc[111];
  endfunction

  task automatic model_load();
    for (int i = 1; i <= 93; i++) ma[i] = 1'b0;
    for (int i = 1; i <= 84; i++) mb[i] = 1'b0;
    for (int i = 1; i <= 111; i++) mc[i] = (i >= 109);
    for (int i = 0; i < 80; i++) begin
      ma[i+1] = key[i];
      mb[i+1] = iv[i];
    end
  endtask

  task automatic model_round();
    logic t1;
    logic t2;
    logic t3;
    t1 = ma[66] ^ ma[93];
    t2 = mb[69] ^ mb[84];
    t3 = mc[66] ^ mc[111];
    t1 = t1 ^ (ma[91] & ma[92]) ^ mb[78];
    t2 = t2 ^ (mb[82] & mb[83]) ^ mc[87];
    t3 = t3 ^ (mc[109] & mc[110]) ^ ma[69];
    for (int i = 93; i > 1; i--) ma[i] = ma[i-1];
    for (int i = 84; i > 1; i--) mb[i] = mb[i-1];
    for (int i = 111; i > 1; i--) mc[i] = mc[i-1];
    ma[1] = t3;
    mb[1] = t1;
    mc[1] = t2;
  endtask

  // One clock with the given enable/start; upper ui_in bits carry junk that must be ignored.
  task automatic tick(input logic e, input logic s);
    logic       exp_v;
    logic       exp_b;
    logic       exp_z;
    logic [1:0] exp_st;
    ena   = e;
    ui_in = {7'b1010110, s};
    if (e) begin
      if (s) begin
        model_load();
        ph     = 1;
        rounds = 0;
      end else if (ph == 1) begin
        model_round();
        rounds++;
        if (rounds == 1152) ph = 2;
      end else if (ph == 2) begin
        model_round();
      end
    end
    @(posedge clk);
    #1;
    exp_v = (ph == 2);
    exp_b = (ph == 1);
    exp_z = exp_v ? model_z() : 1'b0;
`ifdef TRIVIUM_STATUS_EN
    exp_st = {exp_b, exp_v};
`else
    exp_st = 2'b00;
`endif
    check1("keystream_bit", keystream_bit, exp_z);
    check8("uo_out", uo_out, {5'b00000, exp_st, exp_z});
    check1("valid", dut.valid_q, exp_v);
    check1("busy", dut.busy_q, exp_b);
    check8("uio_out|uio_oe", uio_out | uio_oe, 8'h00);
  endtask

  task automatic check_all_zero(input string tag);
    check8({tag, "_uo_out"}, uo_out, 8'h00);
    check8({tag, "_uio_oe"}, uio_oe, 8'h00);
    check8({tag, "_uio_out"}, uio_out, 8'h00);
    check1({tag, "_ks"}, keystream_bit, 1'b0);
    check1({tag, "_valid"}, dut.valid_q, 1'b0);
    check1({tag, "_busy"}, dut.busy_q, 1'b0);
  endtask

  logic kb_hold;

  initial begin
    rst_n  = 1'b1;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'hA5;
    key    = '0;
    iv     = '0;
    ph     = 0;
    rounds = 0;

    // Reset: outputs zero, and held so with ena=1 and even with start asserted.
    #1;
    check_all_zero("rst_async");
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst");
    ena   = 1'b1;
    ui_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst_ena");
    ui_in = 8'h01;
    @(posedge clk);
    #1;
    check_all_zero("rst_start");
    ui_in = 8'h00;
    rst_n = 1'b0;

    // Warm-up timing with key=iv=0. Counting the start edge as clock 1,
    // busy is seen from clock 1 and valid first at clock 1153.
    tbl[0] = '{1'b1, 1'b0, 4,   1'b0, 1'b0, "idle"};
    tbl[1] = '{1'b0, 1'b1, 3,   1'b0, 1'b0, "start_no_ena"};
    tbl[2] = '{1'b1, 1'b1, 1,   1'b0, 1'b1, "start"};
    tbl[3] = '{1'b1, 1'b0, 600, 1'b0, 1'b1, "warm_a"};
    tbl[4] = '{1'b0, 1'b0, 7,   1'b0, 1'b1, "warm_frozen"};
    tbl[5] = '{1'b1, 1'b0, 551, 1'b0, 1'b1, "warm_b"};
    tbl[6] = '{1'b1, 1'b0, 1,   1'b1, 1'b0, "clock_1153"};
    for (int r = 0; r < 7; r++) begin
      for (int c = 0; c < tbl[r].n; c++) begin
        tick(tbl[r].e, tbl[r].s);
        check1({"tbl_valid_", tbl[r].name}, dut.valid_q, tbl[r].v);
        check1({"tbl_busy_", tbl[r].name}, dut.busy_q, tbl[r].b);
      end
    end
    repeat (16) tick(1'b1, 1'b0);

    // Keystream for the reference key: warm-up then 256 bits compared to the model.
    key = 80'h0123456789ABCDEF0123;
    iv  = 80'h0;
    tick(1'b1, 1'b1);
    check1("ks_busy_next", dut.busy_q, 1'b1);
    repeat (1152) tick(1'b1, 1'b0);
    check1("ks_valid_up", dut.valid_q, 1'b1);
    repeat (256) tick(1'b1, 1'b0);

    // Enable freeze in RUN, with start toggling while disabled.
    kb_hold = keystream_bit;
    for (int c = 0; c < 10; c++) begin
      tick(1'b0, c[0]);
      check1("freeze_ks", keystream_bit, kb_hold);
      check1("freeze_valid", dut.valid_q, 1'b1);
    end
    repeat (32) tick(1'b1, 1'b0);

    // Rekey from RUN with a new IV.
    iv = 80'hF00D_CAFE_1234_5678_9ABC;
    tick(1'b1, 1'b1);
    check1("rekey_valid_drop", dut.valid_q, 1'b0);
    repeat (1151) tick(1'b1, 1'b0);
    check1("rekey_valid_pre", dut.valid_q, 1'b0);
    tick(1'b1, 1'b0);
    check1("rekey_valid_up", dut.valid_q, 1'b1);
    repeat (64) tick(1'b1, 1'b0);

    // Reset at warm-up round 500, then a full warm-up from a later start.
    key = 80'hDEAD_BEEF_0000_1111_2222;
    iv  = 80'h1357_9BDF_0246_8ACE_FFFF;
    tick(1'b1, 1'b1);
    repeat (500) tick(1'b1, 1'b0);
    check1("mid_busy_before", dut.busy_q, 1'b1);
    #2;
    rst_n = 1'b1;
    #1;
    check_all_zero("mid_rst");
    ph     = 0;
    rounds = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    check_all_zero("mid_rst_hold");
    repeat (3) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    repeat (1151) tick(1'b1, 1'b0);
    check1("restart_valid_pre", dut.valid_q, 1'b0);
    tick(1'b1, 1'b0);
    check1("restart_valid_up", dut.valid_q, 1'b1);
    repeat (48) tick(1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
